// File: rtl/rr_interval_gen_if.sv
// Handshake bundle between the R-peak front end and its driver/consumer.
// The slave side is the interval generator, and the master side is the stimulus/consumer.
interface rr_interval_gen_if;
  logic       beat_in;
  logic       en;
  logic       rr_ready;
  logic [7:0] rr_out;
  logic       rr_valid;
  logic       overrun;
  logic       lost;

  modport master (
    output beat_in, en, rr_ready,
    input  rr_out, rr_valid, overrun, lost
  );

  modport slave (
    input  beat_in, en, rr_ready,
    output rr_out, rr_valid, overrun, lost
  );
endinterface

// File: rtl/rr_interval_gen.sv
// Beat-to-RR front end: turns a raw R-peak pulse into 8-bit RR intervals in tick units,
// with refractory rejection, lost-rhythm restart and a one-entry output buffer.
module rr_interval_gen #(
  parameter int unsigned TICK_DIV = 80000,
  parameter int unsigned REFRACT  = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_interval_gen_if.slave bus
);

  localparam int unsigned     PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]      REFRACT_V = 8'(REFRACT);
  localparam logic [7:0]      CNT_MAX   = 8'd254;

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  logic          r_rst_meta;
  logic          r_rst_sync;
  logic          w_rst_n;
  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic          w_edge;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [7:0]    r_rr_cnt;
  logic [7:0]    w_cnt_nxt;
  logic          w_tick;
  logic          w_accept;
  logic          w_lost;
  logic [7:0]    r_rr_out;
  logic [7:0]    w_out_nxt;
  logic          r_rr_valid;
  logic          w_valid_nxt;
  logic          r_overrun;
  logic          w_ovr_nxt;
  logic          r_lost;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // beat_in synchroniser plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.beat_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge   = r_s2 & ~r_s3;
  assign w_tick   = (r_state == MEASURE) && (r_presc == TICK_LAST);
  assign w_accept = bus.en && (r_state == MEASURE) && w_edge && (r_rr_cnt >= REFRACT_V);
  // An accepted beat in the same cycle as the 254 tick wins, so no restart then.
  assign w_lost   = bus.en && w_tick && (r_rr_cnt == CNT_MAX) && !w_accept;

  // Next-state, counters and output buffer.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_cnt_nxt   = r_rr_cnt;
    w_out_nxt   = r_rr_out;
    w_valid_nxt = r_rr_valid;
    w_ovr_nxt   = 1'b0;

    if (!bus.en) begin
      w_state_nxt = WAIT_FIRST;
    end else begin
      case (r_state)
        WAIT_FIRST: begin
          if (w_edge) begin
            w_state_nxt = MEASURE;
          end else begin
            w_state_nxt = WAIT_FIRST;
          end
        end
        MEASURE: begin
          if (w_lost) begin
            w_state_nxt = WAIT_FIRST;
          end else begin
            w_state_nxt = MEASURE;
          end
        end
        default: w_state_nxt = WAIT_FIRST;
      endcase
    end

    if ((r_state != MEASURE) || (w_state_nxt != MEASURE) || w_accept) begin
      w_presc_nxt = '0;
      w_cnt_nxt   = 8'd0;
    end else if (w_tick) begin
      w_presc_nxt = '0;
      w_cnt_nxt   = r_rr_cnt + 8'd1;
    end else begin
      w_presc_nxt = r_presc + PW'(1);
      w_cnt_nxt   = r_rr_cnt;
    end

    // A full buffer that is not being drained drops the new interval.
    if (w_accept) begin
      if (r_rr_valid && !bus.rr_ready) begin
        w_ovr_nxt = 1'b1;
      end else begin
        w_out_nxt   = r_rr_cnt;
        w_valid_nxt = 1'b1;
      end
    end else if (r_rr_valid && bus.rr_ready) begin
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = r_rr_valid;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= WAIT_FIRST;
      r_presc    <= '0;
      r_rr_cnt   <= 8'd0;
      r_rr_out   <= 8'd0;
      r_rr_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_rr_cnt   <= w_cnt_nxt;
      r_rr_out   <= w_out_nxt;
      r_rr_valid <= w_valid_nxt;
      r_overrun  <= w_ovr_nxt;
      r_lost     <= w_lost;
    end
  end

  assign bus.rr_out   = r_rr_out;
  assign bus.rr_valid = r_rr_valid;
  assign bus.overrun  = r_overrun;
  assign bus.lost     = r_lost;

endmodule

// File: tb/tb_rr_interval_gen.sv
// Directed bench for rr_interval_gen with TICK_DIV=4, REFRACT=5: a table of beat gaps with
// expected intervals, followed by hand-written lost, backpressure, reset and enable sequences.
module tb_rr_interval_gen;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rr_interval_gen_if bus ();

  rr_interval_gen #(.TICK_DIV(4), .REFRACT(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    bit         ev;
    logic [7:0] er;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts at the third negedge of the previous beat; waits pre negedges, pulses beat_in for
  // two cycles and checks the outputs three posedges after the rise.
  task automatic beat_chk(input int pre, input bit ev, input logic [7:0] er,
                          input bit eo, input string nm);
    repeat (pre) @(negedge clk);
    bus.beat_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.beat_in = 1'b0;
    @(negedge clk);
    chk({nm, ".valid"}, int'(bus.rr_valid), int'(ev));
    if (ev) chk({nm, ".rr_out"}, int'(bus.rr_out), int'(er));
    chk({nm, ".overrun"}, int'(bus.overrun), int'(eo));
    chk({nm, ".lost"}, int'(bus.lost), 0);
  endtask

  initial begin
    int first_lost;
    int pulses;
    total = 0;
    bad   = 0;
    rst_n       = 1'b0;
    bus.beat_in = 1'b0;
    bus.en      = 1'b1;
    bus.rr_ready = 1'b1;

    // Spacing N clocks between accepted beats yields floor((N-1)/4) ticks, plus one if
    // N is a multiple of 4 only when no tick coincides (the coinciding tick is discarded).
    vecs[0]  = '{gap: 8,    ev: 1'b0, er: 8'd0};
    vecs[1]  = '{gap: 401,  ev: 1'b1, er: 8'd100};
    vecs[2]  = '{gap: 401,  ev: 1'b1, er: 8'd100};
    vecs[3]  = '{gap: 401,  ev: 1'b1, er: 8'd100};
    vecs[4]  = '{gap: 400,  ev: 1'b1, er: 8'd99};
    vecs[5]  = '{gap: 13,   ev: 1'b0, er: 8'd0};
    vecs[6]  = '{gap: 188,  ev: 1'b1, er: 8'd50};
    vecs[7]  = '{gap: 17,   ev: 1'b0, er: 8'd0};
    vecs[8]  = '{gap: 4,    ev: 1'b1, er: 8'd5};
    vecs[9]  = '{gap: 801,  ev: 1'b1, er: 8'd200};
    vecs[10] = '{gap: 1020, ev: 1'b1, er: 8'd254};

    repeat (3) @(negedge clk);
    chk("reset.rr_out", int'(bus.rr_out), 0);
    chk("reset.valid", int'(bus.rr_valid), 0);
    chk("reset.overrun", int'(bus.overrun), 0);
    chk("reset.lost", int'(bus.lost), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      beat_chk(vecs[i].gap - 3, vecs[i].ev, vecs[i].er, 1'b0, $sformatf("vec%0d", i));
    end

    // No beat after the 254 interval: lost must fire 1020 clocks after that accept.
    first_lost = -1;
    for (int k = 4; k <= 1100; k++) begin
      @(negedge clk);
      if (bus.lost && first_lost < 0) first_lost = k;
      if (k == 1024) chk("lost.width", int'(bus.lost), 0);
    end
    chk("lost.time", first_lost, 1023);
    beat_chk(10, 1'b0, 8'd0, 1'b0, "lost.origin");
    beat_chk(78, 1'b1, 8'd20, 1'b0, "lost.after");

    // Backpressure: buffered 25 is held, the 30 is dropped, 35 loads while draining.
    @(negedge clk);
    bus.rr_ready = 1'b0;
    beat_chk(97, 1'b1, 8'd25, 1'b0, "bp.load");
    beat_chk(118, 1'b1, 8'd25, 1'b1, "bp.ovr");
    @(negedge clk);
    chk("bp.ovr_width", int'(bus.overrun), 0);
    chk("bp.held", int'(bus.rr_out), 25);
    repeat (137) @(negedge clk);
    bus.beat_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.beat_in  = 1'b0;
    bus.rr_ready = 1'b1;
    @(negedge clk);
    chk("bp.swap.valid", int'(bus.rr_valid), 1);
    chk("bp.swap.rr_out", int'(bus.rr_out), 35);
    chk("bp.swap.overrun", int'(bus.overrun), 0);
    @(negedge clk);
    chk("bp.drain", int'(bus.rr_valid), 0);

    // Asynchronous reset with a pending interval.
    bus.rr_ready = 1'b0;
    beat_chk(97, 1'b1, 8'd25, 1'b0, "rst.pending");
    rst_n = 1'b0;
    #1;
    chk("rst.async.valid", int'(bus.rr_valid), 0);
    chk("rst.async.rr_out", int'(bus.rr_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rr_ready = 1'b1;
    beat_chk(8, 1'b0, 8'd0, 1'b0, "rst.first");
    beat_chk(58, 1'b1, 8'd15, 1'b0, "rst.second");

    // Enable drop forces a new origin; a long-held beat_in gives a single edge.
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    bus.en = 1'b1;
    beat_chk(100, 1'b0, 8'd0, 1'b0, "en.origin");
    repeat (98) @(negedge clk);
    bus.beat_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("sync.lat2", int'(bus.rr_valid), 0);
    @(negedge clk);
    chk("sync.lat3", int'(bus.rr_valid), 1);
    chk("sync.rr_out", int'(bus.rr_out), 25);
    pulses = 0;
    for (int k = 4; k <= 300; k++) begin
      @(negedge clk);
      if (bus.rr_valid) pulses++;
    end
    bus.beat_in = 1'b0;
    chk("held.pulses", pulses, 0);
    beat_chk(101, 1'b1, 8'd100, 1'b0, "held.next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
